// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, op encoding, index width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NCORES_DEF = 2;
  localparam int IDXW       = idxWidth(NCORES_DEF);

endpackage

// File: rtl/mem_arb_if.sv
// Core-side load/store bus plus the DataMEM strobe/data bus seen by the arbiter.
interface mem_arb_if #(
   parameter int Ncores = 2,
   parameter int Lmem   = 8,
   parameter int TAM    = 16
);
   logic [Ncores-1:0]     coreLoad;
   logic [Ncores-1:0]     coreWrite;
   logic [Ncores*TAM-1:0] coreADDR;
   logic [Ncores*TAM-1:0] coreIN;
   logic [Ncores*TAM-1:0] coreOUT;
   logic [Ncores-1:0]     coreReady;
   logic [Lmem-1:0]       memADDR;
   logic [TAM-1:0]        memIN;
   logic                  memLoad;
   logic                  memWrite;
   logic [TAM-1:0]        memOUT;

   // Arbiter view
   modport slave (
      input  coreLoad, coreWrite, coreADDR, coreIN, memOUT,
      output coreOUT, coreReady, memADDR, memIN, memLoad, memWrite
   );

   // Environment view: cores plus memory
   modport master (
      output coreLoad, coreWrite, coreADDR, coreIN, memOUT,
      input  coreOUT, coreReady, memADDR, memIN, memLoad, memWrite
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select. MEMARB_ROUNDROBIN_EN: search starts at ptr; otherwise lowest index wins.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int Ncores = 2,
   parameter int IW     = idxWidth(Ncores)
) (
   input  logic [Ncores-1:0] req,
`ifdef MEMARB_ROUNDROBIN_EN
   input  logic [IW-1:0]     ptr,
`endif
   output logic [IW-1:0]     win,
   output logic              any
);

   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      any = |req;
      // Walk the search order backwards so the first hit in order is the last assignment
      for (int k = Ncores - 1; k >= 0; k--) begin
`ifdef MEMARB_ROUNDROBIN_EN
         idx = (int'(ptr) + k) % Ncores;
`else
         idx = k;
`endif
         if (req[idx]) win = idx[IW-1:0];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port DataMEM among Ncores load/store ports, one transaction per 3 cycles.
// Optional MEMARB_ROUNDROBIN_EN selects round-robin instead of fixed lowest-index priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int Ncores = 2,
   parameter int Lmem   = 8,
   parameter int TAM    = 16
) (
   input  logic     clk,
   input  logic     rst,
   mem_arb_if.slave bus
);

   localparam int IW = idxWidth(Ncores);

   state_e                      state;
   logic   [IW-1:0]             wSel;
   op_e                         opL;
   logic   [Ncores-1:0][TAM-1:0] outReg;
   logic   [Ncores-1:0]         readyR;
   logic   [Lmem-1:0]           addrR;
   logic   [TAM-1:0]            dataR;
   logic                        loadR;
   logic                        writeR;

   logic   [Ncores-1:0]         req;
   logic   [IW-1:0]             win;
   logic                        any;
   op_e                         opSel;
   logic   [Lmem-1:0]           addrSel;
   logic   [TAM-1:0]            dataSel;

   assign req     = bus.coreLoad | bus.coreWrite;
   // Load+write together is a write
   assign opSel   = bus.coreWrite[win] ? OP_WRITE : OP_LOAD;
   assign addrSel = bus.coreADDR[win*TAM +: Lmem];
   assign dataSel = bus.coreIN[win*TAM +: TAM];

   generate
      if (TAM > Lmem) begin : gAddrHi
         // Upper address bits are don't-care: the address wraps modulo 2^Lmem
         logic unusedAddrHi;
         always_comb begin
            unusedAddrHi = 1'b0;
            for (int i = 0; i < Ncores; i++)
               unusedAddrHi = unusedAddrHi ^ (^bus.coreADDR[i*TAM+Lmem +: TAM-Lmem]);
         end
      end
   endgenerate

`ifdef MEMARB_ROUNDROBIN_EN
   logic [IW-1:0] ptr;

   mem_arb_pick #(.Ncores(Ncores), .IW(IW)) uPick (
      .req (req),
      .ptr (ptr),
      .win (win),
      .any (any)
   );
`else
   mem_arb_pick #(.Ncores(Ncores), .IW(IW)) uPick (
      .req (req),
      .win (win),
      .any (any)
   );
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         wSel   <= '0;
         opL    <= OP_LOAD;
         outReg <= '0;
         readyR <= '0;
         addrR  <= '0;
         dataR  <= '0;
         loadR  <= 1'b0;
         writeR <= 1'b0;
`ifdef MEMARB_ROUNDROBIN_EN
         ptr    <= '0;
`endif
      end else begin
         readyR <= '0;
         loadR  <= 1'b0;
         writeR <= 1'b0;
         case (state)
            IDLE: begin
               // A request still held during its own ready cycle counts as a new request
               if (any) begin
                  wSel   <= win;
                  opL    <= opSel;
                  addrR  <= addrSel;
                  dataR  <= dataSel;
                  writeR <= (opSel == OP_WRITE);
                  loadR  <= (opSel == OP_LOAD);
                  state  <= ISSUE;
`ifdef MEMARB_ROUNDROBIN_EN
                  if (int'(win) == Ncores - 1) ptr <= '0;
                  else                         ptr <= win + 1'b1;
`endif
               end
            end
            ISSUE: state <= RESP;
            RESP: begin
               // memOUT is valid this cycle for the load issued in ISSUE
               if (opL == OP_LOAD) outReg[wSel] <= bus.memOUT;
               readyR[wSel] <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.coreOUT   = outReg;
   assign bus.coreReady = readyR;
   assign bus.memADDR   = addrR;
   assign bus.memIN     = dataR;
   assign bus.memLoad   = loadR;
   assign bus.memWrite  = writeR;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-read DataMEM.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int NC = 2;
   localparam int LM = 8;
   localparam int TW = 16;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [TW-1:0] tbMem [256];

   mem_arb_if #(.Ncores(NC), .Lmem(LM), .TAM(TW)) bus ();

   mem_arbiter #(.Ncores(NC), .Lmem(LM), .TAM(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.memWrite) tbMem[bus.memADDR] <= bus.memIN;
      if (bus.memLoad)  bus.memOUT <= tbMem[bus.memADDR];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idleIn();
      bus.coreLoad  = '0;
      bus.coreWrite = '0;
      bus.coreADDR  = '0;
      bus.coreIN    = '0;
   endtask

   task automatic doReset();
      idleIn();
      rst = 1'b0;
      tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 256; i++) tbMem[i] = '0;
      bus.memOUT = '0;
      idleIn();
      rst = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_ready",  bus.coreReady, 0);
      chk("rst_memLd",  bus.memLoad,   0);
      chk("rst_memWr",  bus.memWrite,  0);
      chk("rst_addr",   bus.memADDR,   0);
      chk("rst_memIN",  bus.memIN,     0);
      chk("rst_out",    bus.coreOUT,   0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Core 0 write then read
      bus.coreWrite = 2'b01;
      bus.coreADDR[15:0] = 16'h0012;
      bus.coreIN[15:0]   = 16'hBEEF;
      tick();
      chk("t1_wr_stb",  bus.memWrite, 1);
      chk("t1_wr_ld",   bus.memLoad,  0);
      chk("t1_wr_addr", bus.memADDR,  8'h12);
      chk("t1_wr_data", bus.memIN,    16'hBEEF);
      tick();
      chk("t1_wr_stb2", bus.memWrite, 0);
      chk("t1_rdy_n1",  bus.coreReady, 0);
      tick();
      chk("t1_wr_rdy",  bus.coreReady, 2'b01);
      bus.coreWrite = 2'b00;
      bus.coreLoad  = 2'b01;
      tick();
      chk("t1_ld_stb",  bus.memLoad,  1);
      chk("t1_ld_rdy0", bus.coreReady, 0);
      tick();
      tick();
      chk("t1_ld_rdy",  bus.coreReady, 2'b01);
      chk("t1_ld_out",  bus.coreOUT[15:0], 16'hBEEF);
      idleIn();
      tick();
      chk("t1_no_dup",  bus.memLoad | bus.memWrite, 0);
      tick();
      tick();
      chk("t1_no_rdy",  bus.coreReady, 0);

      // Simultaneous writes, then simultaneous readback
      doReset();
      bus.coreWrite = 2'b11;
      bus.coreADDR  = {16'h0006, 16'h0005};
      bus.coreIN    = {16'h2222, 16'h1111};
      tick();
      chk("t2_w0_addr", bus.memADDR, 8'h05);
      chk("t2_w0_data", bus.memIN,   16'h1111);
      tick();
      tick();
      chk("t2_w0_rdy",  bus.coreReady, 2'b01);
      bus.coreWrite = 2'b10;
      tick();
      chk("t2_w1_stb",  bus.memWrite, 1);
      chk("t2_w1_addr", bus.memADDR, 8'h06);
      chk("t2_w1_data", bus.memIN,   16'h2222);
      tick();
      tick();
      chk("t2_w1_rdy",  bus.coreReady, 2'b10);
      bus.coreWrite = 2'b00;
      bus.coreLoad  = 2'b11;
      tick();
      tick();
      tick();
      chk("t2_r0_rdy",  bus.coreReady, 2'b01);
      chk("t2_r0_out",  bus.coreOUT[15:0], 16'h1111);
      bus.coreLoad = 2'b10;
      tick();
      tick();
      tick();
      chk("t2_r1_rdy",  bus.coreReady, 2'b10);
      chk("t2_r1_out",  bus.coreOUT[31:16], 16'h2222);
      chk("t2_r0_hold", bus.coreOUT[15:0], 16'h1111);
      idleIn();
      tick();

      // Both cores hold loads for 12 cycles
      doReset();
      bus.coreLoad = 2'b11;
      bus.coreADDR = {16'h0006, 16'h0005};
      for (int i = 1; i <= 12; i++) begin
         logic [1:0] expRdy;
         tick();
         expRdy = 2'b00;
`ifdef MEMARB_ROUNDROBIN_EN
         if (i % 3 == 0) expRdy = ((i / 3) % 2 == 1) ? 2'b01 : 2'b10;
`else
         if (i % 3 == 0) expRdy = 2'b01;
`endif
         chk($sformatf("t3_rdy_c%0d", i), bus.coreReady, expRdy);
      end
      chk("t3_out0", bus.coreOUT[15:0], 16'h1111);
`ifdef MEMARB_ROUNDROBIN_EN
      chk("t3_out1", bus.coreOUT[31:16], 16'h2222);
      idleIn();
      tick();
      chk("t3_quiet", bus.memLoad, 0);
`else
      chk("t3_starved", bus.coreOUT[31:16], 16'h0000);
      bus.coreLoad = 2'b10;
      tick();
      chk("t3_c1_stb",  bus.memLoad, 1);
      chk("t3_c1_addr", bus.memADDR, 8'h06);
      tick();
      tick();
      chk("t3_c1_rdy",  bus.coreReady, 2'b10);
      chk("t3_out1",    bus.coreOUT[31:16], 16'h2222);
      idleIn();
      tick();
`endif

      // Load+write together on core 1, address wraps
      bus.coreLoad  = 2'b10;
      bus.coreWrite = 2'b10;
      bus.coreADDR  = {16'h01FF, 16'h0000};
      bus.coreIN    = {16'hA5A5, 16'h0000};
      tick();
      chk("t4_wr_stb",  bus.memWrite, 1);
      chk("t4_ld_stb",  bus.memLoad,  0);
      chk("t4_addr",    bus.memADDR,  8'hFF);
      chk("t4_data",    bus.memIN,    16'hA5A5);
      tick();
      chk("t4_rdy0",    bus.coreReady, 0);
      tick();
      chk("t4_rdy",     bus.coreReady, 2'b10);
      chk("t4_out1",    bus.coreOUT[31:16], 16'h2222);
      idleIn();
      tick();
      chk("t4_single",  bus.coreReady, 0);
      chk("t4_mem",     tbMem[8'hFF], 16'hA5A5);
      tick();
      tick();
      chk("t4_no_rdy",  bus.coreReady, 0);

      // Reset during ISSUE of a write
      bus.coreWrite = 2'b01;
      bus.coreADDR  = {16'h0000, 16'h0033};
      bus.coreIN    = {16'h0000, 16'h7777};
      tick();
      chk("t5_stb",     bus.memWrite, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_wr_drop", bus.memWrite, 0);
      chk("t5_addr",    bus.memADDR,  0);
      chk("t5_data",    bus.memIN,    0);
      chk("t5_out",     bus.coreOUT,  0);
      chk("t5_state",   dut.state,    IDLE);
      idleIn();
      tick();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_no_rdy%0d", i), bus.coreReady, 0);
      end
      chk("t5_mem",     tbMem[8'h33], 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port DataMEM instance (Lmem-bit address, TAM-bit data, 1-cycle synchronous read) among Ncores core-side load/store ports. Each core issues a load or write and holds it until a one-cycle ready pulse. The arbiter grants one core at a time, drives the memory strobes, and returns read data. It sits between the core load/store units and the data memory.

Parameters:
Ncores, 2, number of requesting cores
Lmem, 8, memory address width (2^Lmem words)
TAM, 16, data word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
coreLoad  in  Ncores  per-core load request
coreWrite  in  Ncores  per-core write request
coreADDR  in  Ncores*TAM  per-core address, core i at bits [i*TAM +: TAM]
coreIN  in  Ncores*TAM  per-core write data
coreOUT  out  Ncores*TAM  per-core registered read data
coreReady  out  Ncores  per-core one-cycle completion pulse
memADDR  out  Lmem  memory address
memIN  out  TAM  memory write data
memLoad  out  1  memory read strobe
memWrite  out  1  memory write strobe
memOUT  in  TAM  memory read data, valid the cycle after memLoad

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, coreOUT=0, coreReady=0, memLoad=0, memWrite=0, memADDR=0, memIN=0, priority pointer=0. Any in-flight transaction is dropped with no ready pulse.
- Request protocol: core i asserts coreLoad[i] and/or coreWrite[i] with address and data stable, and holds them until coreReady[i]=1. It deasserts in the cycle after the ready pulse or issues a new request.
- If coreLoad[i] and coreWrite[i] are both set, the request is treated as a write only. There is one ready pulse.
- FSM: IDLE -> ISSUE -> RESP -> IDLE. One transaction per 3 cycles.
  - IDLE: if any request is pending, pick winner w, latch w, op, addr[Lmem-1:0] and data. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive memADDR and memIN from the latch. Assert memWrite (write) or memLoad (load) for exactly this cycle. Go to RESP.
  - RESP: for a load, capture memOUT into coreOUT[w]. Pulse coreReady[w] for this cycle. Go to IDLE.
- Latency: request sampled at edge N. ISSUE occupies cycle N..N+1. coreReady[w]=1 and coreOUT[w] are valid after edge N+2.
- Core requests are not re-sampled in ISSUE or RESP. A core that drops its request mid-transaction still receives the ready pulse (protocol violation, no abort).
- Upper TAM-Lmem address bits are ignored (the address wraps modulo 2^Lmem).
- coreOUT[i] holds its last read value until core i's next load completes. Writes do not alter coreOUT.
- At most one coreReady bit is high in any cycle. memLoad and memWrite are never both high. Strobes are 0 outside ISSUE.
- Priority pointer: with round-robin enabled, after granting w the pointer becomes (w+1) mod Ncores, and the search order starts at the pointer.

Optional Feature:
MEMARB_ROUNDROBIN_EN
- Defined: round-robin selection as above. Every continuously requesting core is served within Ncores transactions.
- Undefined: fixed priority, lowest index wins, and the pointer register is omitted. Core 0 can starve the other cores.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, RESP)
  - localparam IDXW = max(1, $clog2(Ncores))
  - op encoding (OP_LOAD, OP_WRITE)
- Sub-module mem_arb_pick: combinational winner select from the request vector and pointer, with the MEMARB_ROUNDROBIN_EN switch inside.

Test Plan:
- Write then read, core 0: coreWrite[0] with addr 0x0012, data 0xBEEF, then coreLoad[0] with addr 0x0012. Expected: memWrite high 1 cycle with memADDR=0x12; coreReady[0] 2 cycles after each request edge; coreOUT[0]=0xBEEF.
- Simultaneous writes: core 0 (0x05, 0x1111) and core 1 (0x06, 0x2222) at the same edge. Expected: core 0 served first and core 1 three cycles later. Readback gives 0x1111 and 0x2222.
- Fairness (MEMARB_ROUNDROBIN_EN defined): both cores hold loads continuously for 12 cycles. Expected: ready sequence core0, core1, core0, core1, one pulse per 3 cycles.
- Fixed priority (macro undefined): same stimulus as the fairness test. Expected: only core 0 receives ready pulses; core 1 waits until core 0 drops its request.
- Load and write asserted together on core 1, addr 0x1FF, data 0xA5A5. Expected: memWrite only; memADDR=0xFF (wrap); single coreReady[1]; coreOUT[1] unchanged.
- Reset mid-transaction: rst=0 during ISSUE of a write. Expected: memWrite drops immediately, no coreReady pulse, state IDLE, all outputs 0.
